sbox_substitute: RTL

Sequential DES substitution stage that compresses the 48-bit round value back to 32 bits. It sits between the key-mixing XOR and the P-permutation, in the opposite direction of the 32→48 expansion step. It evaluates the eight standard DES S-boxes one per clock through a single shared lookup. This trades eight cycles of latency for one lookup datapath, and it uses a valid/ready handshake on both sides.

---
 rtl/sbox_substitute.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sbox_substitute.sv
// DES S-box substitution stage: 48-bit key-mixed value in, 32-bit S1..S8 nibble
// concatenation out, one box per clock through a single shared lookup.
module sbox_substitute (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [47:0] shift_r;
  logic [2:0]  cnt_r;
  logic [31:0] result_r;
  logic [3:0]  sbox_s;

  // Row word for (box, row): 16 nibbles, column 0 in the most significant nibble.
  function automatic logic [63:0] sbox_row(input logic [2:0] box, input logic [1:0] row);
    logic [63:0] w;
    case ({box, row})
      5'd0:    w = 64'hE4D12FB83A6C5907;
      5'd1:    w = 64'h0F74E2D1A6CB9538;
      5'd2:    w = 64'h41E8D62BFC973A50;
      5'd3:    w = 64'hFC8249175B3EA06D;
      5'd4:    w = 64'hF18E6B34972DC05A;
      5'd5:    w = 64'h3D47F28EC01A69B5;
      5'd6:    w = 64'h0E7BA4D158C6932F;
      5'd7:    w = 64'hD8A13F42B67C05E9;
      5'd8:    w = 64'hA09E63F51DC7B428;
      5'd9:    w = 64'hD709346A285ECBF1;
      5'd10:   w = 64'hD6498F30B12C5AE7;
      5'd11:   w = 64'h1AD069874FE3B52C;
      5'd12:   w = 64'h7DE3069A1285BC4F;
      5'd13:   w = 64'hD8B56F03472C1AE9;
      5'd14:   w = 64'hA690CB7DF13E5284;
      5'd15:   w = 64'h3F06A1D8945BC72E;
      5'd16:   w = 64'h2C417AB6853FD0E9;
      5'd17:   w = 64'hEB2C47D150FA3986;
      5'd18:   w = 64'h421BAD78F9C5630E;
      5'd19:   w = 64'hB8C71E2D6F09A453;
      5'd20:   w = 64'hC1AF92680D34E75B;
      5'd21:   w = 64'hAF427C9561DE0B38;
      5'd22:   w = 64'h9EF528C3704A1DB6;
      5'd23:   w = 64'h432C95FABE17608D;
      5'd24:   w = 64'h4B2EF08D3C975A61;
      5'd25:   w = 64'hD0B7491AE35C2F86;
      5'd26:   w = 64'h14BDC37EAF680592;
      5'd27:   w = 64'h6BD814A7950FE23C;
      5'd28:   w = 64'hD2846FB1A93E50C7;
      5'd29:   w = 64'h1FD8A374C56B0E92;
      5'd30:   w = 64'h7B419CE206ADF358;
      5'd31:   w = 64'h21E74A8DFC90356B;
      default: w = 64'h0;
    endcase
    return w;
  endfunction

  // Six-bit DES S-box input: outer bits pick the row, inner four the column.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
    logic [63:0] w;
    logic [5:0]  lsb;
    w   = sbox_row(box, {b[5], b[0]});
    lsb = 6'd60 - {b[4:1], 2'b00};
    return w[lsb +: 4];
  endfunction

  // Shared lookup for the box currently at the top of the shift register.
  always_comb begin
    sbox_s = sbox_lookup(cnt_r, shift_r[47:42]);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = SUB;
        else          state_s = IDLE;
      end
      SUB: begin
        if (cnt_r == 3'd7) state_s = DONE;
        else               state_s = SUB;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Capture, shift and accumulate datapath; result holds through DONE and IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_r  <= 48'h0;
      cnt_r    <= 3'd0;
      result_r <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            shift_r  <= in_data;
            cnt_r    <= 3'd0;
            result_r <= 32'h0;
          end
        end
        SUB: begin
          shift_r  <= {shift_r[41:0], 6'd0};
          cnt_r    <= cnt_r + 3'd1;
          result_r <= {result_r[27:0], sbox_s};
        end
        default: begin
          shift_r  <= shift_r;
          cnt_r    <= cnt_r;
          result_r <= result_r;
        end
      endcase
    end
  end

  // Handshake flags depend on the state register only.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == SUB) || (state_r == DONE);
  assign out_data  = result_r;

endmodule
